// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: FSM states, decoded op kinds and cycle counts.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MduIdle,
        MduMul,
        MduDiv,
        MduDfix
    } mdu_state_e;

    typedef enum logic [2:0] {
        OpNone,
        OpMult,
        OpMultu,
        OpDiv,
        OpDivu,
        OpMthi,
        OpMtlo
    } mdu_op_e;

    // 32 iteration cycles plus one sign-fix/writeback cycle
    localparam int unsigned MduDivCycles = 33;

    function automatic mdu_op_e decode_op(input logic mult, input logic multu, input logic div,
                                          input logic divu, input logic mthi, input logic mtlo);
        if (mult)  return OpMult;
        if (multu) return OpMultu;
        if (div)   return OpDiv;
        if (divu)  return OpDivu;
        if (mthi)  return OpMthi;
        if (mtlo)  return OpMtlo;
        return OpNone;
    endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Restoring divider core on unsigned 32-bit magnitudes; one quotient bit per cycle after start.
module mdu_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    logic [31:0] rem_q, quo_q, dvs_q;
    logic [5:0]  cnt_q;
    logic [32:0] shifted;
    logic        fits;

    // Partial remainder shifted left with the next dividend bit from the quotient register
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= a;
            dvs_q <= b;
            cnt_q <= 6'd32;
        end else if (cnt_q != '0) begin
            rem_q <= fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
            quo_q <= {quo_q[30:0], fits};
            cnt_q <= cnt_q - 6'd1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = (cnt_q == '0);

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; multi-cycle, one op in flight, cancellable.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_q, state_d;
    mdu_op_e          op;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      prod_q, product, ext_a, ext_b;
    logic [31:0]      a_q, mag_a, mag_b, div_quo, div_rem, res_quo, res_rem;
    logic             quo_neg_q, rem_neg_q, div_zero_q;
    logic             accept_mul, accept_div, mul_signed, div_signed, div_valid;

    // cancel suppresses acceptance even of a same-cycle strobe
    assign op         = (en && !cancel) ? decode_op(mult, multu, div, divu, mthi, mtlo) : OpNone;
    assign accept_mul = (state_q == MduIdle) && (op == OpMult || op == OpMultu);
    assign accept_div = (state_q == MduIdle) && (op == OpDiv || op == OpDivu);
    assign mul_signed = (op == OpMult);
    assign div_signed = (op == OpDiv);

    assign ext_a   = {{32{mul_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{mul_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;
    assign mag_a   = (div_signed && op_a[31]) ? -op_a : op_a;
    assign mag_b   = (div_signed && op_b[31]) ? -op_b : op_b;
    assign res_quo = quo_neg_q ? -div_quo : div_quo;
    assign res_rem = rem_neg_q ? -div_rem : div_rem;

    mdu_divider u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept_div),
        .a         (mag_a),
        .b         (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MduIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MduIdle: begin
                if (accept_mul)      state_d = MduMul;
                else if (accept_div) state_d = MduDiv;
            end
            MduMul:  if (cancel || cnt_q == '0) state_d = MduIdle;
            MduDiv: begin
                if (cancel)                    state_d = MduIdle;
                else if (cnt_q == CNT_W'(1))   state_d = MduDfix;
            end
            MduDfix: if (cancel || div_valid) state_d = MduIdle;
            default: state_d = MduIdle;
        endcase
    end

    // cnt holds remaining busy cycles minus one
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        busy_d = (state_d != MduIdle);
        if (state_q == MduIdle) begin
            if (accept_mul) cnt_d = CNT_W'(MULT_CYCLES - 1);
            if (accept_div) cnt_d = CNT_W'(MduDivCycles - 1);
            if (op == OpMthi) hi_d = op_a;
            if (op == OpMtlo) lo_d = op_a;
        end else if (cancel) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (state_q == MduMul && cnt_q == '0) begin
                {hi_d, lo_d} = prod_q;
                done_d       = 1'b1;
            end
            if (state_q == MduDfix && div_valid) begin
                hi_d   = div_zero_q ? a_q : res_rem;
                lo_d   = div_zero_q ? 32'hFFFF_FFFF : res_quo;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            prod_q     <= '0;
            a_q        <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            if (accept_mul) prod_q <= product;
            if (accept_div) begin
                a_q        <= op_a;
                quo_neg_q  <= div_signed & (op_a[31] ^ op_b[31]);
                rem_neg_q  <= div_signed & op_a[31];
                div_zero_q <= (op_b == '0);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops against an arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int MC = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, mult = 1'b0, multu = 1'b0, div = 1'b0, divu = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    mult_div_unit #(.MULT_CYCLES(MC), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mult   (mult),
        .multu  (multu),
        .div    (div),
        .divu   (divu),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .op_a   (op_a),
        .op_b   (op_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected {hi,lo}
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                check("result_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // kind: 0 none, 1 mthi/mtlo, 2 multiply, 3 divide
    function automatic void ref_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                                   output int kind, output logic [31:0] rh, output logic [31:0] rl);
        int sa, sb;
        longint pa, pb;
        longint unsigned up;
        sa = a;
        sb = b;
        rh = m_hi;
        rl = m_lo;
        kind = 0;
        if (s[5]) begin
            pa = sa;
            pb = sb;
            {rh, rl} = pa * pb;
            kind = 2;
        end else if (s[4]) begin
            up = {32'b0, a};
            up = up * {32'b0, b};
            {rh, rl} = up;
            kind = 2;
        end else if (s[3]) begin
            kind = 3;
            if (b == 0) begin
                rh = a;
                rl = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rh = 0;
                rl = 32'h8000_0000;
            end else begin
                rl = sa / sb;
                rh = sa % sb;
            end
        end else if (s[2]) begin
            kind = 3;
            if (b == 0) begin
                rh = a;
                rl = 32'hFFFF_FFFF;
            end else begin
                rl = a / b;
                rh = a % b;
            end
        end else if (s[1]) begin
            rh = a;
            kind = 1;
        end else if (s[0]) begin
            rl = a;
            kind = 1;
        end
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge where busy has dropped.
    task automatic run_op(input string name, input logic [5:0] s, input logic [31:0] a,
                          input logic [31:0] b, input int cancel_at, input bit sneak);
        int kind, n, exp_n;
        logic [31:0] rh, rl, ph, pl;
        ref_op(s, a, b, kind, rh, rl);
        ph = m_hi;
        pl = m_lo;
        {mult, multu, div, divu, mthi, mtlo} = s;
        en = 1'b1;
        op_a = a;
        op_b = b;
        @(negedge clk);
        {mult, multu, div, divu, mthi, mtlo} = '0;
        en = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        if (kind == 1) begin
            m_hi = rh;
            m_lo = rl;
            check({name, "_busy"}, busy, 0);
            check({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
            return;
        end
        exp_n = (kind == 2) ? MC : 33;
        if (cancel_at == 0) begin
            exp_q.push_back({rh, rl});
            m_hi = rh;
            m_lo = rl;
        end else begin
            exp_n = cancel_at;
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == cancel_at) cancel = 1'b1;
            if (sneak && n == 3) begin
                en = 1'b1;
                mtlo = 1'b1;
                op_a = $urandom;
            end
            @(negedge clk);
            if (sneak && n == 3) check({name, "_mtlo_ignored"}, lo, pl);
            cancel = 1'b0;
            en = 1'b0;
            mtlo = 1'b0;
        end
        check({name, "_busy_cycles"}, n, exp_n);
        if (cancel_at != 0) begin
            check({name, "_cancel_no_done"}, done, 0);
            check({name, "_cancel_hilo"}, {hi, lo}, {ph, pl});
        end
    endtask

    initial begin
        logic [5:0] s;
        logic [31:0] a, b;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, hi, lo}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult", 6'b100000, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op("multu", 6'b010000, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op("div_neg", 6'b001000, -32'sd7, 32'd2, 0, 0);
        run_op("divu_zero", 6'b000100, 32'd7, 32'd0, 0, 0);
        run_op("div_zero", 6'b001000, 32'h8000_0005, 32'd0, 0, 0);
        run_op("div_ovf", 6'b001000, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("mthi", 6'b000010, 32'h0000_1234, 32'd0, 0, 0);
        run_op("mtlo", 6'b000001, 32'hCAFE_F00D, 32'd0, 0, 0);
        run_op("div_sneak", 6'b001000, $urandom, $urandom_range(1, 1000), 0, 1);
        run_op("div_cancel10", 6'b001000, 32'd100, 32'd3, 10, 0);
        run_op("mult_after_cancel", 6'b100000, 32'd12345, 32'hFFFF_FFF0, 0, 0);
        run_op("mult_cancel_last", 6'b100000, 32'd3, 32'd4, MC, 0);
        run_op("div_cancel_last", 6'b001000, 32'd99, 32'd5, 33, 0);
        run_op("prio_mult", 6'b110011, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0);
        run_op("prio_div", 6'b001111, 32'hFFFF_FF00, 32'd7, 0, 0);
        run_op("prio_mthi", 6'b000011, 32'h5555_AAAA, 32'd0, 0, 0);

        // cancel in idle beats a same-cycle strobe
        en = 1'b1;
        mthi = 1'b1;
        div = 1'b1;
        op_a = 32'hDEAD_BEEF;
        cancel = 1'b1;
        @(negedge clk);
        {en, mthi, div, cancel} = '0;
        check("idle_cancel_busy", busy, 0);
        check("idle_cancel_hilo", {hi, lo}, {m_hi, m_lo});

        for (int i = 0; i < 40; i++) begin
            s = 6'b000001 << $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            run_op("random", s, a, b, 0, 0);
        end

        // asynchronous reset mid-divide
        div = 1'b1;
        en = 1'b1;
        op_a = 32'd1000;
        op_b = 32'd7;
        @(negedge clk);
        {div, en} = '0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_div", {busy, done, hi, lo}, '0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("mult_after_reset", 6'b100000, 32'd6, 32'd7, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
